opti_input_feeder: RTL
======================

Name: opti_input_feeder

Overview:
- Input-side sequencer for the optimized IIR SOS cascade.
- On start, reads the input sample buffer (synchronous ROM/RAM, 1-cycle read latency) from address 0 upward and presents each sample to the cascade input with a valid/ready handshake at a programmable minimum spacing.
- After the last stored sample it appends FLUSH_LEN zero samples, so the downstream output controller can finish its settling window and collect the full output block.

Parameters:
- NUM_SAMPLES, 2048: samples read from the buffer, addresses 0..NUM_SAMPLES-1.
- FLUSH_LEN, 237: zero samples appended after the buffer samples; 0 disables the flush.
- SPACING, 4: minimum cycles between consecutive transfer cycles; legal range 3..255.
- AW, 11: buffer address width.
- DW, 16: sample width, two's complement.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a feed run; sampled only in IDLE or DONE.
- rom_en  out  1  buffer read enable; one-cycle pulse per read.
- rom_addr  out  AW  buffer read address.
- rom_data  in  DW  buffer read data; valid the cycle after rom_en.
- sos_in_ready  in  1  cascade accepts a sample this cycle.
- sos_in_valid  out  1  sample on sos_in_data is valid; doubles as data_in_valid to the output controller.
- sos_in_data  out  DW  sample to the cascade.
- busy  out  1  run in progress.
- feed_done  out  1  all NUM_SAMPLES+FLUSH_LEN samples transferred; held high until the next start.

Behaviour:
- Reset, asynchronous: every output is 0, state is IDLE and all counters are 0.
- Reset asserted mid-run aborts the run immediately. No sample is replayed after release.
- States and transitions:
  - IDLE/DONE: on start, clear feed_done and counters, set rom_addr=0 and busy=1, go to READ.
  - READ, 1 cycle: during the buffer phase, rom_en=1 with the current rom_addr. During the flush phase, no read is issued. Always go to LOAD.
  - LOAD, 1 cycle: capture rom_data, or 0 in the flush phase, into sos_in_data. Set sos_in_valid=1. Go to SEND.
  - SEND: hold sos_in_valid and sos_in_data stable until sos_in_ready=1.
    - The transfer cycle is valid && ready. The next cycle has sos_in_valid=0 and sample_cnt+1.
    - During the buffer phase, rom_addr increments after each transfer.
    - After transfer NUM_SAMPLES+FLUSH_LEN: go to DONE with busy=0 and feed_done=1.
    - Otherwise go to GAP, or directly to READ when SPACING=3.
  - GAP: wait SPACING-3 cycles, then go to READ.
- Spacing: transfer-to-transfer distance is exactly SPACING cycles when ready is held high, and larger when ready stalls.
- Phase selection: sample_cnt < NUM_SAMPLES is the buffer phase; otherwise the flush phase.
  - sample_cnt is wide enough to hold NUM_SAMPLES+FLUSH_LEN (12 bits at defaults).
- rom_addr stops at NUM_SAMPLES-1 and never wraps. It holds that value through flush and DONE.
- start while busy is ignored. start in DONE restarts the run cleanly from address 0.
- A ready pulse while sos_in_valid=0 has no effect. There is no combinational path from ready to valid.
- Simultaneous start and rst_n low: reset wins.

Test Plan:
- Reset, then start with NUM_SAMPLES=4, FLUSH_LEN=2, SPACING=4, ready tied 1, ROM[i]=0x0100+i -> sos_in_data sequence 0x0100,0x0101,0x0102,0x0103,0,0. Transfers are exactly 4 cycles apart. feed_done rises the cycle after the 6th transfer.
- Same setup, ready low for 5 cycles during sample 2 -> valid and data=0x0102 held stable for the whole stall. Exactly one transfer occurs. rom_addr does not advance until that transfer.
- Defaults, ready=1 -> 2285 transfers, rom_addr peaks at 2047 with no wrap, 2048 rom_en pulses, last 237 samples are 0, busy falls together with feed_done rising.
- start pulsed mid-run at sample 10 -> ignored, sample count unchanged. start after DONE -> feed_done clears and rom_addr=0 on the first read.
- rst_n asserted during SEND of sample 7 -> all outputs 0 asynchronously. After release, idle until start.
- FLUSH_LEN=0, SPACING=3 -> back-to-back transfers every 3 cycles. No zero samples. feed_done follows the NUM_SAMPLES-th transfer.

Source files
------------

// File: rtl/opti_input_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : opti_input_feeder
//  Brief    : Input-side sequencer for the IIR SOS cascade. Reads the sample
//             buffer from address 0 upward, presents each sample with a
//             valid/ready handshake at a minimum spacing, then appends
//             FLUSH_LEN zero samples so the output side can settle.
//  Revision : 1.0  initial release
// ============================================================================
module opti_input_feeder #(
  parameter int NUM_SAMPLES = 2048,
  parameter int FLUSH_LEN   = 237,
  parameter int SPACING     = 4,
  parameter int AW          = 11,
  parameter int DW          = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          rom_en,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  input  logic          sos_in_ready,
  output logic          sos_in_valid,
  output logic [DW-1:0] sos_in_data,
  output logic          busy,
  output logic          feed_done
);

  localparam int              c_total     = NUM_SAMPLES + FLUSH_LEN;
  localparam int              c_cnt_w     = $clog2(c_total + 1);
  localparam logic [c_cnt_w-1:0] c_num    = c_cnt_w'(NUM_SAMPLES);
  localparam logic [c_cnt_w-1:0] c_last   = c_cnt_w'(c_total - 1);
  localparam logic [AW-1:0]   c_last_addr = AW'(NUM_SAMPLES - 1);
  // READ + LOAD + SEND already account for three cycles of the spacing;
  // the gap counter covers the remainder and counts down to zero.
  localparam bit              c_use_gap   = (SPACING > 3);
  localparam logic [7:0]      c_gap_load  = 8'((SPACING > 3) ? (SPACING - 4) : 0);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_LOAD = 3'd2,
    S_SEND = 3'd3,
    S_GAP  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [c_cnt_w-1:0]   r_sample_cnt;
  logic [7:0]           r_gap_cnt;
  logic                 w_buffer_phase;
  logic                 w_start_ok;
  logic                 w_xfer;
  logic                 w_last_xfer;
  logic                 w_addr_step;

  assign w_buffer_phase = (r_sample_cnt < c_num);
  assign w_start_ok     = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_xfer         = (r_state == S_SEND) && sos_in_valid && sos_in_ready;
  assign w_last_xfer    = w_xfer && (r_sample_cnt == c_last);
  // The address saturates at the last buffer entry so it never wraps.
  assign w_addr_step    = w_xfer && w_buffer_phase && (rom_addr != c_last_addr);

  // Buffer read is issued only in READ and only while buffer samples remain.
  assign rom_en = (r_state == S_READ) && w_buffer_phase;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) w_next = S_READ;
      end
      S_READ: w_next = S_LOAD;
      S_LOAD: w_next = S_SEND;
      S_SEND: begin
        if (w_xfer) begin
          if (w_last_xfer)    w_next = S_DONE;
          else if (c_use_gap) w_next = S_GAP;
          else                w_next = S_READ;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == 8'd0) w_next = S_READ;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: address, counters, handshake and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr     <= '0;
      r_sample_cnt <= '0;
      r_gap_cnt    <= '0;
      sos_in_valid <= 1'b0;
      sos_in_data  <= '0;
      busy         <= 1'b0;
      feed_done    <= 1'b0;
    end else begin
      if (w_start_ok) begin
        rom_addr     <= '0;
        r_sample_cnt <= '0;
        r_gap_cnt    <= '0;
        sos_in_valid <= 1'b0;
        busy         <= 1'b1;
        feed_done    <= 1'b0;
      end

      if (r_state == S_LOAD) begin
        sos_in_data  <= w_buffer_phase ? rom_data : '0;
        sos_in_valid <= 1'b1;
      end

      if (w_xfer) begin
        sos_in_valid <= 1'b0;
        r_sample_cnt <= r_sample_cnt + c_cnt_w'(1);
        r_gap_cnt    <= c_gap_load;
        if (w_addr_step) rom_addr <= rom_addr + AW'(1);
        if (w_last_xfer) begin
          busy      <= 1'b0;
          feed_done <= 1'b1;
        end
      end

      if ((r_state == S_GAP) && (r_gap_cnt != 8'd0)) begin
        r_gap_cnt <= r_gap_cnt - 8'd1;
      end
    end
  end

endmodule
`default_nettype wire
